// File: rtl/fetch_stage.sv
// fetch_stage: PC sequencer with 1-cycle imem reads, a DEPTH-entry instruction queue and redirect flush
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [31:0]   fetch_pc_q, req_pc_q;
  logic [CW-1:0] count_q;
  logic          inflight_q;
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [31:0]   instr_q [DEPTH];
  logic [31:0]   pc_q    [DEPTH];
  logic [CW:0]   occ;
  logic          pop, wr;
  assign if_valid  = ~rst & (count_q != '0);
  assign if_instr  = if_valid ? instr_q[rd_ptr_q] : '0;
  assign if_pc     = if_valid ? pc_q[rd_ptr_q] : '0;
  assign pop       = if_valid & if_ready & ~redirect;
  // A response in the redirect cycle belongs to the old stream and is dropped.
  assign wr        = ~rst & ~redirect & inflight_q;
  assign occ       = {1'b0, count_q} + (CW+1)'(inflight_q) - (CW+1)'(pop);
  assign imem_req  = ~rst & ~redirect & (occ < (CW+1)'(DEPTH));
  assign imem_addr = fetch_pc_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      count_q    <= '0;
      inflight_q <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else if (redirect) begin
      fetch_pc_q <= redirect_pc & ~32'h3;
      count_q    <= '0;
      inflight_q <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      if (imem_req) begin
        fetch_pc_q <= fetch_pc_q + 32'd4;
        req_pc_q   <= fetch_pc_q;
      end
      inflight_q <= imem_req;
      if (wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(wr) - CW'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (wr) begin
      instr_q[wr_ptr_q] <= imem_rdata;
      pc_q[wr_ptr_q]    <= req_pc_q;
    end
  end
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(wr && count_q == CW'(DEPTH) && !pop));
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed fetch/stall/redirect/reset cases plus a random run against a pc-stream scoreboard
module tb_fetch_stage;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  logic        clk = 1'b0;
  logic        rst, imem_req, redirect, if_valid, if_ready;
  logic [31:0] imem_addr, redirect_pc, if_instr, if_pc;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] exp_q [$];
  logic [31:0] nxt;
  int          vec = 0, err = 0, pops = 0, n, p0;
  fetch_stage #(.RESET_PC(RESET_PC), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] f(input logic [31:0] a);
    return {~a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction
  always @(posedge clk) imem_rdata <= imem_req ? f(imem_addr) : 32'hDEAD_BEEF;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec++;
    if (got !== exp) begin
      err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic reload(input logic [31:0] b);
    exp_q.delete();
    nxt = b;
    repeat (8) begin
      exp_q.push_back(nxt);
      nxt += 32'd4;
    end
  endtask
  task automatic tick();
    logic [31:0] e;
    @(negedge clk);
    if (rst) reload(RESET_PC);
    else if (redirect) reload(redirect_pc & ~32'h3);
    else if (if_valid && if_ready) begin
      e = exp_q.pop_front();
      exp_q.push_back(nxt);
      nxt += 32'd4;
      pops++;
      chk("sb_pc", if_pc, e);
      chk("sb_instr", if_instr, f(e));
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; if_ready = 1'b1;
    tick();
    chk("rst_req", imem_req, 0);
    chk("rst_valid", if_valid, 0);
    chk("rst_instr", if_instr, 0);
    chk("rst_pc", if_pc, 0);
    tick();
    rst = 1'b0; #1;
    chk("t1_req", imem_req, 1);
    chk("t1_addr", imem_addr, 32'h0);
    tick();
    chk("t1_lat", if_valid, 0);
    tick();
    chk("t1_v0", if_valid, 1);
    chk("t1_pc0", if_pc, 32'h0);
    tick();
    chk("t1_pc4", if_pc, 32'h4);
    tick();
    chk("t1_v8", if_valid, 1);
    chk("t1_pc8", if_pc, 32'h8);
    rst = 1'b1;
    tick();
    rst = 1'b0; if_ready = 1'b0; #1;
    n = 0;
    repeat (6) begin
      n += int'(imem_req);
      tick();
    end
    chk("t2_reqs", n, 2);
    chk("t2_pc", if_pc, 32'h0);
    chk("t2_instr", if_instr, f(32'h0));
    tick(); tick();
    chk("t2_hold_pc", if_pc, 32'h0);
    chk("t2_hold_instr", if_instr, f(32'h0));
    if_ready = 1'b1; #1;
    chk("t2_pc0", if_pc, 32'h0);
    tick();
    chk("t2_pc4", if_pc, 32'h4);
    tick();
    chk("t2_v8", if_valid, 1);
    chk("t2_pc8", if_pc, 32'h8);
    redirect = 1'b1; redirect_pc = 32'h100; #1;
    chk("t3_noreq", imem_req, 0);
    tick();
    redirect = 1'b0; #1;
    chk("t3_flush", if_valid, 0);
    chk("t3_req", imem_req, 1);
    chk("t3_addr", imem_addr, 32'h100);
    tick();
    chk("t3_lat", if_valid, 0);
    tick();
    chk("t3_v", if_valid, 1);
    chk("t3_pc", if_pc, 32'h100);
    redirect = 1'b1; redirect_pc = 32'h103; #1;
    chk("t4_headv", if_valid, 1);
    tick();
    redirect = 1'b0; #1;
    chk("t4_flush", if_valid, 0);
    chk("t4_addr", imem_addr, 32'h100);
    tick(); tick();
    chk("t4_pc", if_pc, 32'h100);
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    tick();
    redirect = 1'b0;
    tick(); tick();
    chk("t5_pc0", if_pc, 32'hFFFF_FFF8);
    tick();
    chk("t5_pc1", if_pc, 32'hFFFF_FFFC);
    tick();
    chk("t5_v2", if_valid, 1);
    chk("t5_pc2", if_pc, 32'h0);
    tick();
    rst = 1'b1; #1;
    chk("t6_req", imem_req, 0);
    chk("t6_valid", if_valid, 0);
    chk("t6_instr", if_instr, 0);
    chk("t6_pc", if_pc, 0);
    tick();
    rst = 1'b0; #1;
    chk("t6_addr", imem_addr, RESET_PC);
    tick();
    chk("t6_stale", if_valid, 0);
    tick();
    chk("t6_v", if_valid, 1);
    chk("t6_first", if_pc, RESET_PC);
    p0 = pops;
    repeat (400) begin
      if_ready = ($urandom_range(3) != 0);
      redirect = ($urandom_range(15) == 0);
      redirect_pc = $urandom;
      tick();
    end
    redirect = 1'b0;
    chk("rand_progress", 32'(pops - p0 > 100), 1);
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
